mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - MEM-stage consumer of the EX->MEM pipeline register outputs. Turns a registered load/store into a
//   req/ack data-bus transaction, stalls the pipeline until it completes, returns the formatted load data.
// - Sits between the EX->MEM register outputs and the data-RAM bus; feeds MEM->WB with load data.
// PARAMETERS
// - OP_W        `INST_OP_BUS_WIDTH   width of inst_op_in
// - TIMEOUT     16                   max BUSY cycles without bus_ack before a bus error is flagged (>=1)
// PORTS
// - clk             in   1     single clock, rising edge
// - rst             in   1     reset: asynchronous, active-low
// - ram_en_in       in   1     access requested by the instruction now in MEM
// - ram_write_en_in in   1     1=store, 0=load (valid when ram_en_in)
// - inst_op_in      in   OP_W  LB/LBU/LH/LHU/LW/SB/SH/SW opcode
// - result_in       in   32    effective byte address
// - reg_data_2_in   in   32    store data, right-aligned
// - stall_request   out  1     hold the pipeline (drives stall_current_stage upstream)
// - load_data_out   out  32    sign/zero-extended load result
// - access_done     out  1     one-cycle pulse: access retired
// - addr_err        out  1     with access_done: misaligned address, no bus access made
// - bus_err         out  1     with access_done: TIMEOUT expired
// - bus_req         out  1     bus request, held until bus_ack
// - bus_we          out  1     bus write enable
// - bus_addr        out  32    word address, {result_in[31:2],2'b00}
// - bus_sel         out  4     byte lanes; bit i = bits [8i+7:8i]
// - bus_wdata       out  32    store data replicated into lanes
// - bus_ack         in   1     slave done; bus_rdata valid in the same cycle
// - bus_rdata       in   32    read word
// BEHAVIOUR
// - Reset: state=IDLE; every output 0; timeout counter 0. rst asserted mid-transaction drops bus_req
//   immediately and abandons the access; no access_done is produced for it.
// - FSM IDLE -> BUSY -> DONE -> IDLE. All bus outputs, load_data_out, and flags are registered.
// - IDLE: when ram_en_in=1:
//   - Alignment check: halfword requires addr[0]=0, word requires addr[1:0]=0.
//   - Aligned: latch op/addr/data, drive bus_req=1 next cycle, go BUSY.
//   - Misaligned: go DONE with addr_err=1; bus stays idle.
// - BUSY: bus_req/bus_we/bus_addr/bus_sel/bus_wdata held stable. Counter increments every cycle.
//   - On bus_ack: drop bus_req next cycle, capture formatted rdata (loads only), go DONE.
//   - Counter reaching TIMEOUT with no ack: drop bus_req, bus_err=1, load_data_out=0, go DONE.
//   - bus_ack in the same cycle as expiry counts as success.
// - DONE: one cycle. access_done=1, stall_request=0. ram_en_in is ignored because the same instruction
//   is still presented. Unconditionally return to IDLE.
// - stall_request = (IDLE & ram_en_in) | BUSY. Combinational, so the pipeline holds from the first cycle.
//   Minimum access = 3 cycles (IDLE, BUSY with ack, DONE).
// - Store lanes:
//   - SB: sel=1<<addr[1:0], wdata={4{d[7:0]}}.
//   - SH: sel=addr[1]?4'b1100:4'b0011, wdata={2{d[15:0]}}.
//   - SW: sel=4'b1111, wdata=d.
// - Loads: bus_sel=4'b1111. Byte/half are taken from the addressed lane; LB/LH sign-extend, LBU/LHU
//   zero-extend. load_data_out is held until the next capture; stores leave it unchanged.
// - Unknown opcode with ram_en_in=1 is treated as LW.
// STRUCTURE
// - Opcode constants (LB..SW) and data/address widths come from the shared global_def header.
// - Add FSM state encodings (IDLE/BUSY/DONE) to that header.
// - One combinational sub-module: mem_byte_lane (store lane/sel generation and load extraction/extension).
//   FSM and counter live in the top.
// TESTING
// - SW addr=0x100 data=0xDEADBEEF, ack on 2nd BUSY cycle -> bus_addr=0x100, sel=1111, we=1;
//   stall high 3 cycles; access_done on cycle 4.
// - LB addr=0x103, rdata=0x80FF_0000 -> load_data_out=0xFFFFFF80. LBU same -> 0x00000080.
// - LH addr=0x102, rdata=0x1234_5678 -> sel=1111, load_data_out=0x00001234.
//   SH addr=0x102 data=0xABCD -> sel=1100, wdata=0xABCDABCD.
// - LW addr=0x101 -> addr_err=1 with access_done; bus_req never asserted; stall high exactly 1 cycle.
// - LW, bus_ack never arrives, TIMEOUT=16 -> bus_err pulse after 16 BUSY cycles; bus_req deasserted;
//   pipeline released.
// - rst low during BUSY -> all outputs 0 asynchronously. After release, next LW completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: widths, opcode
// encodings, FSM states and small opcode/alignment helpers.
package mem_access_unit_pkg;

  localparam int DATA_W            = 32;
  localparam int ADDR_W            = 32;
  localparam int INST_OP_BUS_WIDTH = 4;

  typedef logic [INST_OP_BUS_WIDTH-1:0] op_t;

  localparam op_t OP_LB  = 4'd0;
  localparam op_t OP_LBU = 4'd1;
  localparam op_t OP_LH  = 4'd2;
  localparam op_t OP_LHU = 4'd3;
  localparam op_t OP_LW  = 4'd4;
  localparam op_t OP_SB  = 4'd5;
  localparam op_t OP_SH  = 4'd6;
  localparam op_t OP_SW  = 4'd7;

  // state   | meaning
  // IDLE    | waiting for ram_en_in; alignment check happens here
  // BUSY    | bus_req held, waiting for bus_ack or timeout
  // DONE    | one-cycle retire: access_done pulse, pipeline released
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Unknown opcodes fall into the word bucket so they behave as LW.
  function automatic size_t op_size(input op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  function automatic logic op_signed(input op_t op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic op_is_store(input op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic addr_aligned(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return ~lo[0];
      SZ_WORD: return (lo == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for the data bus: store select/replication on the way
// out and lane extraction with sign/zero extension on the way back.
module mem_byte_lane
  import mem_access_unit_pkg::*;
(
  input  op_t               op,
  input  logic              store,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        sel,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sext;

  // Store side: loads always request the full word.
  always_comb begin
    sel   = 4'b1111;
    wdata = store_data;
    if (store) begin
      case (op_size(op))
        SZ_BYTE: begin
          sel   = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        SZ_HALF: begin
          sel   = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load side: pick the addressed lane, then extend.
  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sext      = op_signed(op);
    load_data = rdata;
    case (op_size(op))
      SZ_BYTE: load_data = {{24{sext & lane_b[7]}}, lane_b};
      SZ_HALF: load_data = {{16{sext & lane_h[15]}}, lane_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns the registered EX->MEM access into a
// req/ack bus transaction, stalls the pipeline while it is in flight and
// returns the formatted load result.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int OP_W    = INST_OP_BUS_WIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_en_in,
  input  logic              ram_write_en_in,
  input  logic [OP_W-1:0]   inst_op_in,
  input  logic [ADDR_W-1:0] result_in,
  input  logic [DATA_W-1:0] reg_data_2_in,
  output logic              stall_request,
  output logic [DATA_W-1:0] load_data_out,
  output logic              access_done,
  output logic              addr_err,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  op_t               op_q;
  logic [1:0]        addr_lo_q;
  logic              store_q;

  op_t               op_cur;
  logic              cur_store;
  logic              cur_aligned;
  logic              expire;
  logic              in_idle;

  op_t               lane_op;
  logic              lane_store;
  logic [1:0]        lane_addr_lo;
  logic [3:0]        lane_sel;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_load;

  assign op_cur      = op_t'(inst_op_in);
  assign cur_store   = ram_write_en_in & op_is_store(op_cur);
  assign cur_aligned = addr_aligned(op_size(op_cur), result_in[1:0]);
  // Last permitted BUSY cycle; counter value is the number of BUSY cycles already spent.
  assign expire      = (cnt == CNT_W'(TIMEOUT - 1));
  assign in_idle     = (state == ST_IDLE);

  // One lane unit serves both directions: in IDLE it formats the incoming
  // store, afterwards it extracts from bus_rdata using the latched access.
  assign lane_op      = in_idle ? op_cur : op_q;
  assign lane_store   = in_idle ? cur_store : store_q;
  assign lane_addr_lo = in_idle ? result_in[1:0] : addr_lo_q;

  mem_byte_lane u_lane (
    .op         (lane_op),
    .store      (lane_store),
    .addr_lo    (lane_addr_lo),
    .store_data (reg_data_2_in),
    .rdata      (bus_rdata),
    .sel        (lane_sel),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode and the combinational stall (gated so reset forces it low).
  always_comb begin
    state_nxt     = state;
    stall_request = rst & ((in_idle & ram_en_in) | (state == ST_BUSY));
    case (state)
      ST_IDLE: if (ram_en_in) state_nxt = cur_aligned ? ST_BUSY : ST_DONE;
      ST_BUSY: if (bus_ack || expire) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered bus outputs, result, retire flags and timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      op_q          <= '0;
      addr_lo_q     <= '0;
      store_q       <= 1'b0;
      load_data_out <= '0;
      access_done   <= 1'b0;
      addr_err      <= 1'b0;
      bus_err       <= 1'b0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_sel       <= '0;
      bus_wdata     <= '0;
    end else begin
      access_done <= 1'b0;
      addr_err    <= 1'b0;
      bus_err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ram_en_in) begin
            if (cur_aligned) begin
              op_q      <= op_cur;
              addr_lo_q <= result_in[1:0];
              store_q   <= cur_store;
              cnt       <= '0;
              bus_req   <= 1'b1;
              bus_we    <= cur_store;
              bus_addr  <= {result_in[ADDR_W-1:2], 2'b00};
              bus_sel   <= lane_sel;
              bus_wdata <= lane_wdata;
            end else begin
              access_done <= 1'b1;
              addr_err    <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (bus_ack) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            access_done <= 1'b1;
            if (!store_q) load_data_out <= lane_load;
          end else if (expire) begin
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            access_done   <= 1'b1;
            bus_err       <= 1'b1;
            load_data_out <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected retire and
// bus-request records; a negedge monitor pops and compares them.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en_in, ram_write_en_in;
  logic [3:0]  inst_op_in;
  logic [31:0] result_in, reg_data_2_in;
  logic        stall_request, access_done, addr_err, bus_err;
  logic [31:0] load_data_out;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ram_en_in(ram_en_in), .ram_write_en_in(ram_write_en_in),
    .inst_op_in(inst_op_in), .result_in(result_in), .reg_data_2_in(reg_data_2_in),
    .stall_request(stall_request), .load_data_out(load_data_out),
    .access_done(access_done), .addr_err(addr_err), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        aerr;
    logic        berr;
    logic [31:0] ld;
    int          stall;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  bus_t cur_bus;
  logic bus_active = 1'b0;
  int   stall_cnt  = 0;
  int   n_tests    = 0;
  int   n_fail     = 0;
  int   slave_delay = 0;
  logic [31:0] slave_rdata = 32'h0;
  logic [31:0] last_load   = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---- reference model: plain arithmetic on the access rules ----
  function automatic int size_of(input logic [3:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int          sz;
    logic [31:0] v;
    sz = size_of(op);
    v  = rd >> (8 * (addr % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (op == OP_LB && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (op == OP_LH && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Bus slave: acks on the slave_delay-th cycle of bus_req (0 = never).
  initial begin
    int scnt;
    scnt      = 0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_req && rst) begin
        scnt++;
        if (slave_delay != 0 && scnt == slave_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = slave_rdata;
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = $urandom;
        end
      end else begin
        scnt    = 0;
        bus_ack = 1'b0;
      end
    end
  end

  // Monitor: retire records on access_done, bus records while bus_req is high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (stall_request) stall_cnt++;
        if (bus_req) begin
          if (!bus_active) begin
            bus_active = 1'b1;
            if (bus_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL bus_req_unexpected actual=1 expected=0 addr=0x%08h", bus_addr);
              cur_bus = '{we: bus_we, addr: bus_addr, sel: bus_sel, wdata: bus_wdata};
            end else begin
              cur_bus = bus_q.pop_front();
            end
          end
          chk("bus_we", {31'd0, bus_we}, {31'd0, cur_bus.we});
          chk("bus_addr", bus_addr, cur_bus.addr);
          chk("bus_sel", {28'd0, bus_sel}, {28'd0, cur_bus.sel});
          if (cur_bus.we) chk("bus_wdata", bus_wdata, cur_bus.wdata);
        end else begin
          bus_active = 1'b0;
        end
        if (access_done) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL access_done_unexpected actual=1 expected=0");
          end else begin
            e = exp_q.pop_front();
            chk("addr_err", {31'd0, addr_err}, {31'd0, e.aerr});
            chk("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
            chk("load_data_out", load_data_out, e.ld);
            chk("stall_cycles", stall_cnt, e.stall);
            chk("bus_req_in_done", {31'd0, bus_req}, 32'd0);
            chk("stall_in_done", {31'd0, stall_request}, 32'd0);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  // Issue one access, record expectations, wait (bounded) for its retirement.
  task automatic do_access(input logic [3:0] op, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input int delay, input logic [31:0] rd);
    int   sz, cyc;
    logic store, aligned;
    exp_t e;
    bus_t b;
    sz      = size_of(op);
    store   = we && (op == OP_SB || op == OP_SH || op == OP_SW);
    aligned = (addr % sz) == 0;
    if (!aligned) begin
      e = '{aerr: 1'b1, berr: 1'b0, ld: last_load, stall: 1};
    end else begin
      b.we    = store;
      b.addr  = addr & 32'hFFFF_FFFC;
      b.sel   = 4'hF;
      b.wdata = data;
      if (store && sz == 1) begin
        b.sel   = 4'(1 << (addr % 4));
        b.wdata = (data & 32'hFF) * 32'h0101_0101;
      end else if (store && sz == 2) begin
        b.sel   = ((addr % 4) >= 2) ? 4'hC : 4'h3;
        b.wdata = (data & 32'hFFFF) * 32'h0001_0001;
      end
      bus_q.push_back(b);
      if (delay == 0) begin
        last_load = 32'h0;
        e = '{aerr: 1'b0, berr: 1'b1, ld: 32'h0, stall: 1 + TIMEOUT};
      end else begin
        if (!store) last_load = model_load(op, addr, rd);
        e = '{aerr: 1'b0, berr: 1'b0, ld: last_load, stall: 1 + delay};
      end
    end
    exp_q.push_back(e);
    slave_delay = delay;
    slave_rdata = rd;
    @(posedge clk);
    #1;
    ram_en_in       = 1'b1;
    ram_write_en_in = we;
    inst_op_in      = op;
    result_in       = addr;
    reg_data_2_in   = data;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!access_done && cyc < 100);
    ram_en_in = 1'b0;
    if (!access_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL access_done_timeout actual=%0d_cycles expected=done", cyc);
      exp_q.delete();
      bus_q.delete();
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, stall_request}, 32'd0);
    chk({tag, "_load"}, load_data_out, 32'd0);
    chk({tag, "_flags"}, {29'd0, access_done, addr_err, bus_err}, 32'd0);
    chk({tag, "_req_we"}, {30'd0, bus_req, bus_we}, 32'd0);
    chk({tag, "_addr"}, bus_addr, 32'd0);
    chk({tag, "_sel"}, {28'd0, bus_sel}, 32'd0);
    chk({tag, "_wdata"}, bus_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] addr;
    int          dly;
    rst = 1'b0;
    ram_en_in = 1'b0; ram_write_en_in = 1'b0;
    inst_op_in = 4'd0; result_in = 32'h0; reg_data_2_in = 32'h0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    do_access(OP_SW,  1'b1, 32'h100, 32'hDEADBEEF, 2, 32'h0);
    do_access(OP_LB,  1'b0, 32'h103, 32'h0, 1, 32'h80FF_0000);
    do_access(OP_LBU, 1'b0, 32'h103, 32'h0, 1, 32'h80FF_0000);
    do_access(OP_LH,  1'b0, 32'h102, 32'h0, 3, 32'h1234_5678);
    do_access(OP_SH,  1'b1, 32'h102, 32'h0000_ABCD, 1, 32'h0);
    do_access(OP_LW,  1'b0, 32'h101, 32'h0, 1, 32'h0);
    do_access(OP_LW,  1'b0, 32'h104, 32'h0, 0, 32'h0);
    do_access(OP_LW,  1'b0, 32'h108, 32'h0, TIMEOUT, 32'hCAFE_F00D);
    do_access(4'hF,   1'b0, 32'h10C, 32'h0, 1, 32'h8765_4321);

    // Reset during BUSY: access abandoned, outputs cleared asynchronously.
    bus_q.push_back('{we: 1'b0, addr: 32'h200, sel: 4'hF, wdata: 32'h0});
    slave_delay = 0;
    @(posedge clk);
    #1;
    ram_en_in = 1'b1; ram_write_en_in = 1'b0; inst_op_in = OP_LW; result_in = 32'h200;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    exp_q.delete();
    bus_q.delete();
    bus_active = 1'b0;
    stall_cnt  = 0;
    last_load  = 32'h0;
    ram_en_in  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_access(OP_LW, 1'b0, 32'h204, 32'h0, 2, 32'h0BAD_F00D);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 8))
        0: op = OP_LB;  1: op = OP_LBU; 2: op = OP_LH;  3: op = OP_LHU;
        4: op = OP_LW;  5: op = OP_SB;  6: op = OP_SH;  7: op = OP_SW;
        default: op = 4'hE;
      endcase
      addr = $urandom;
      dly  = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 4);
      do_access(op, (op == OP_SB || op == OP_SH || op == OP_SW), addr, $urandom, dly, $urandom);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0 || bus_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d_left expected=0", exp_q.size() + bus_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
